// File: rtl/usb2_token_rx_pkg.sv
// Shared USB 2.0 definitions for the receive-side token decoder: PIDs,
// rejection codes, CRC5 constants and the CRC5 field calculation.
package usb2_token_rx_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_PID  = 2'd1;
    localparam logic [1:0] ERR_CRC  = 2'd2;
    localparam logic [1:0] ERR_LEN  = 2'd3;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_PID  = 3'd2,
        ST_B1   = 3'd3,
        ST_B2   = 3'd4,
        ST_TAIL = 3'd5,
        ST_SKIP = 3'd6,
        ST_BAD  = 3'd7
    } rx_state_e;

    function automatic logic is_token(input logic [3:0] pid);
        logic tok;
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING: tok = 1'b1;
            default:                                       tok = 1'b0;
        endcase
        return tok;
    endfunction

    // Returns the CRC5 laid out as it sits in F[15:11]: bit 0 holds the x^4 term.
    function automatic logic [4:0] crc5_field(input logic [10:0] d);
        logic [4:0] c;
        logic       fb;
        c = CRC5_INIT;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ ({5{fb}} & CRC5_POLY);
        end
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4]};
    endfunction

endpackage

// File: rtl/usb2_crc5_chk.sv
// Combinational CRC5 check of a token's 16-bit field (11 data bits + 5 CRC bits).
module usb2_crc5_chk
    import usb2_token_rx_pkg::*;
(
    input  logic [15:0] f,
    output logic        crc_ok
);

    assign crc_ok = (f[15:11] == crc5_field(f[10:0]));

endmodule

// File: rtl/usb2_token_rx.sv
// USB 2.0 token packet decoder: checks PID, length and CRC5 of each received
// packet and emits a one-cycle decoded-token or rejection strobe at packet end.
module usb2_token_rx
    import usb2_token_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_active,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_err,
    input  logic [6:0]  dev_addr,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] tok_frame,
    output logic        tok_match,
    output logic        tok_err,
    output logic [1:0]  err_code
);

    rx_state_e   state_r, state_n;
    logic [3:0]  pid_r, pid_n;
    logic [7:0]  b1_r, b1_n;
    logic [7:0]  b2_r, b2_n;
    logic [1:0]  errc_r, errc_n;
    logic        fire_ok_s, fire_err_s;
    logic [1:0]  fire_code_s;
    logic        pid_ok_s;
    logic        crc_ok_s;
    logic [15:0] field_s;

    assign field_s  = {b2_r, b1_r};
    assign pid_ok_s = (in_data[7:4] == ~in_data[3:0]);

    usb2_crc5_chk u_crc5 (
        .f      (field_s),
        .crc_ok (crc_ok_s)
    );

    // Packet FSM state and captured bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_SYNC;
            pid_r   <= 4'd0;
            b1_r    <= 8'd0;
            b2_r    <= 8'd0;
            errc_r  <= ERR_NONE;
        end else begin
            state_r <= state_n;
            pid_r   <= pid_n;
            b1_r    <= b1_n;
            b2_r    <= b2_n;
            errc_r  <= errc_n;
        end
    end

    // Next-state, byte capture and end-of-packet verdict.
    always_comb begin
        state_n     = state_r;
        pid_n       = pid_r;
        b1_n        = b1_r;
        b2_n        = b2_r;
        errc_n      = errc_r;
        fire_ok_s   = 1'b0;
        fire_err_s  = 1'b0;
        fire_code_s = ERR_NONE;
        if (state_r == ST_SYNC) begin
            if (!in_active) state_n = ST_IDLE;
            else            state_n = ST_SYNC;
        end else if (state_r == ST_IDLE && !in_active) begin
            state_n = ST_IDLE;
        end else if (!in_active) begin
            // End of packet: in_valid in this cycle is deliberately ignored.
            state_n = ST_IDLE;
            case (state_r)
                ST_TAIL: begin
                    if (crc_ok_s) begin
                        fire_ok_s = 1'b1;
                    end else begin
                        fire_err_s  = 1'b1;
                        fire_code_s = ERR_CRC;
                    end
                end
                ST_PID, ST_B1, ST_B2: begin
                    fire_err_s  = 1'b1;
                    fire_code_s = ERR_LEN;
                end
                ST_BAD: begin
                    fire_err_s  = 1'b1;
                    fire_code_s = errc_r;
                end
                default: begin
                    fire_ok_s = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                // IDLE with in_active high also accepts a PID byte arriving in the same cycle.
                ST_IDLE, ST_PID: begin
                    if (in_err) begin
                        state_n = ST_BAD;
                        errc_n  = ERR_LEN;
                    end else if (in_valid) begin
                        pid_n = in_data[3:0];
                        if (!pid_ok_s) begin
                            state_n = ST_BAD;
                            errc_n  = ERR_PID;
                        end else if (is_token(in_data[3:0])) begin
                            state_n = ST_B1;
                        end else begin
                            state_n = ST_SKIP;
                        end
                    end else begin
                        state_n = ST_PID;
                    end
                end
                ST_B1: begin
                    if (in_err) begin
                        state_n = ST_BAD;
                        errc_n  = ERR_LEN;
                    end else if (in_valid) begin
                        b1_n    = in_data;
                        state_n = ST_B2;
                    end else begin
                        state_n = ST_B1;
                    end
                end
                ST_B2: begin
                    if (in_err) begin
                        state_n = ST_BAD;
                        errc_n  = ERR_LEN;
                    end else if (in_valid) begin
                        b2_n    = in_data;
                        state_n = ST_TAIL;
                    end else begin
                        state_n = ST_B2;
                    end
                end
                ST_TAIL: begin
                    if (in_err || in_valid) begin
                        state_n = ST_BAD;
                        errc_n  = ERR_LEN;
                    end else begin
                        state_n = ST_TAIL;
                    end
                end
                ST_SKIP: state_n = ST_SKIP;
                ST_BAD:  state_n = ST_BAD;
                default: state_n = ST_SYNC;
            endcase
        end
    end

    // Registered strobes; decoded fields and error code hold until the next strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_valid <= 1'b0;
            tok_err   <= 1'b0;
            err_code  <= ERR_NONE;
            tok_pid   <= 4'd0;
            tok_addr  <= 7'd0;
            tok_endp  <= 4'd0;
            tok_frame <= 11'd0;
            tok_match <= 1'b0;
        end else begin
            tok_valid <= fire_ok_s;
            tok_err   <= fire_err_s;
            if (fire_err_s) err_code <= fire_code_s;
            if (fire_ok_s) begin
                tok_pid <= pid_r;
                if (pid_r == PID_SOF) begin
                    tok_addr  <= 7'd0;
                    tok_endp  <= 4'd0;
                    tok_frame <= field_s[10:0];
                    tok_match <= 1'b0;
                end else begin
                    tok_addr  <= field_s[6:0];
                    tok_endp  <= field_s[10:7];
                    tok_frame <= 11'd0;
                    tok_match <= (field_s[6:0] == dev_addr);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb2_token_rx.sv
// Directed self-checking bench for usb2_token_rx with hand-computed token bytes.
module tb_usb2_token_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_active = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_err = 1'b0;
    logic [6:0]  dev_addr = 7'd0;
    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] tok_frame;
    logic        tok_match;
    logic        tok_err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    usb2_token_rx dut (
        .clk       (clk),
        .reset     (reset),
        .in_active (in_active),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_err    (in_err),
        .dev_addr  (dev_addr),
        .tok_valid (tok_valid),
        .tok_pid   (tok_pid),
        .tok_addr  (tok_addr),
        .tok_endp  (tok_endp),
        .tok_frame (tok_frame),
        .tok_match (tok_match),
        .tok_err   (tok_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic begin_pkt;
        @(posedge clk); #1;
        in_active = 1'b1; in_valid = 1'b0; in_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic err);
        repeat (gap) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_err = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = b; in_err = err;
    endtask

    // Drops in_active and leaves time at the negedge of the cycle where it is first sampled low.
    task automatic finish_pkt;
        @(posedge clk); #1;
        in_active = 1'b0; in_valid = 1'b0; in_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0000", {tok_valid, tok_err, err_code});
        end
        n_cmp++; if ({tok_pid, tok_addr, tok_endp, tok_frame, tok_match} !== 27'd0) begin
            n_bad++; $display("FAIL reset_fields: got %h want 0", {tok_pid, tok_addr, tok_endp, tok_frame, tok_match});
        end
    endtask

    task automatic test_setup;
        dev_addr = 7'd0;
        begin_pkt; send_byte(8'h2D, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h10, 0, 1'b0);
        finish_pkt;
        n_cmp++; if (tok_valid !== 1'b0) begin
            n_bad++; $display("FAIL setup_early: tok_valid got %b want 0", tok_valid);
        end
        @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err} !== 2'b10) begin
            n_bad++; $display("FAIL setup_strobe: valid/err got %b want 10", {tok_valid, tok_err});
        end
        n_cmp++; if ({tok_pid, tok_addr, tok_endp, tok_match} !== {4'hD, 7'd0, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL setup_fields: pid %h addr %h endp %h match %b want D 0 0 1", tok_pid, tok_addr, tok_endp, tok_match);
        end
        @(negedge clk);
        n_cmp++; if (tok_valid !== 1'b0) begin
            n_bad++; $display("FAIL setup_one_cycle: tok_valid got %b want 0", tok_valid);
        end
    endtask

    task automatic test_sof;
        dev_addr = 7'd0;
        begin_pkt; send_byte(8'hA5, 1, 1'b0); send_byte(8'h01, 2, 1'b0); send_byte(8'hE8, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if (tok_valid !== 1'b1) begin
            n_bad++; $display("FAIL sof_valid: got %b want 1", tok_valid);
        end
        n_cmp++; if ({tok_pid, tok_frame, tok_addr, tok_endp, tok_match} !== {4'h5, 11'd1, 7'd0, 4'd0, 1'b0}) begin
            n_bad++; $display("FAIL sof_fields: pid %h frame %h addr %h endp %h match %b want 5 1 0 0 0", tok_pid, tok_frame, tok_addr, tok_endp, tok_match);
        end
    endtask

    task automatic test_crc_err;
        begin_pkt; send_byte(8'h2D, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h18, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0110) begin
            n_bad++; $display("FAIL crc_err: valid/err/code got %b want 0110", {tok_valid, tok_err, err_code});
        end
        n_cmp++; if ({tok_pid, tok_frame} !== {4'h5, 11'd1}) begin
            n_bad++; $display("FAIL crc_hold: pid %h frame %h want 5 1", tok_pid, tok_frame);
        end
    endtask

    task automatic test_pid_err;
        begin_pkt; send_byte(8'h2C, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h10, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0101) begin
            n_bad++; $display("FAIL pid_err: valid/err/code got %b want 0101", {tok_valid, tok_err, err_code});
        end
        begin_pkt; send_byte(8'hC3, 0, 1'b0); send_byte(8'h11, 0, 1'b1); send_byte(8'h22, 1, 1'b0); send_byte(8'h33, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err} !== 2'b00) begin
            n_bad++; $display("FAIL data_silent: valid/err got %b want 00", {tok_valid, tok_err});
        end
        @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0001) begin
            n_bad++; $display("FAIL data_silent_after: valid/err/code got %b want 0001", {tok_valid, tok_err, err_code});
        end
    endtask

    task automatic test_length;
        begin_pkt; send_byte(8'h69, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h10, 0, 1'b0); send_byte(8'h55, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0111) begin
            n_bad++; $display("FAIL len_long: valid/err/code got %b want 0111", {tok_valid, tok_err, err_code});
        end
        // PID error first, then in_err: the first code must survive.
        begin_pkt; send_byte(8'h2C, 0, 1'b0); send_byte(8'h00, 0, 1'b1); send_byte(8'h10, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0101) begin
            n_bad++; $display("FAIL err_priority: valid/err/code got %b want 0101", {tok_valid, tok_err, err_code});
        end
        begin_pkt; send_byte(8'h69, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0111) begin
            n_bad++; $display("FAIL len_short: valid/err/code got %b want 0111", {tok_valid, tok_err, err_code});
        end
        begin_pkt; send_byte(8'h2C, 0, 1'b0);
        finish_pkt; @(negedge clk);
        begin_pkt; send_byte(8'h69, 0, 1'b0); send_byte(8'h00, 0, 1'b1); send_byte(8'h10, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, err_code} !== 4'b0111) begin
            n_bad++; $display("FAIL rx_error: valid/err/code got %b want 0111", {tok_valid, tok_err, err_code});
        end
    endtask

    task automatic test_back_to_back;
        dev_addr = 7'd1;
        begin_pkt;
        send_byte(8'h69, $urandom_range(0, 3), 1'b0);
        send_byte(8'h00, $urandom_range(0, 3), 1'b0);
        send_byte(8'h10, $urandom_range(0, 3), 1'b0);
        @(posedge clk); #1;
        in_active = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        in_active = 1'b1;
        n_cmp++; if ({tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match} !== {2'b10, 4'h9, 7'd0, 4'd0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_first: valid %b err %b pid %h addr %h endp %h match %b want 1 0 9 0 0 0",
                              tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match);
        end
        send_byte(8'h69, $urandom_range(0, 3), 1'b0);
        send_byte(8'h01, $urandom_range(0, 3), 1'b0);
        send_byte(8'hE8, $urandom_range(0, 3), 1'b0);
        finish_pkt;
        n_cmp++; if (tok_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_gap: tok_valid got %b want 0", tok_valid);
        end
        @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match} !== {2'b10, 4'h9, 7'd1, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL b2b_second: valid %b err %b pid %h addr %h endp %h match %b want 1 0 9 1 0 1",
                              tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match);
        end
    endtask

    task automatic test_reset_mid;
        dev_addr = 7'd1;
        begin_pkt; send_byte(8'h69, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        #1;
        n_cmp++; if ({tok_valid, tok_err, err_code, tok_pid, tok_addr, tok_match} !== 16'd0) begin
            n_bad++; $display("FAIL reset_mid_clear: got %h want 0", {tok_valid, tok_err, err_code, tok_pid, tok_addr, tok_match});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_byte(8'h10, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid_silent: valid/err got %b want 00", {tok_valid, tok_err});
        end
        begin_pkt; send_byte(8'h2D, 0, 1'b0); send_byte(8'h01, 0, 1'b0); send_byte(8'hE8, 0, 1'b0);
        finish_pkt; @(negedge clk);
        n_cmp++; if ({tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match} !== {2'b10, 4'hD, 7'd1, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL reset_mid_next: valid %b err %b pid %h addr %h endp %h match %b want 1 0 D 1 0 1",
                              tok_valid, tok_err, tok_pid, tok_addr, tok_endp, tok_match);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        test_setup;
        test_sof;
        test_crc_err;
        test_pid_err;
        test_length;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
